// File: rtl/trig_seq_pkg.sv
// Shared definitions for the trigger sequencer: register offsets, CTRL/STATUS
// bit positions, FSM state encoding and small helpers.
package trig_seq_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_FCOUNT = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_BIT  = 1;
  localparam int CTRL_ALT_BIT   = 2;
  localparam int CTRL_START_BIT = 3;
  localparam int CTRL_ABORT_BIT = 4;
  localparam int CTRL_IRQEN_BIT = 8;

  localparam int STAT_OVR_LSB     = 16;
  localparam int STAT_OVR_CLR_BIT = 30;
  localparam int STAT_DONE_BIT    = 31;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic irq_en;
    logic alt;
    logic mode;
    logic enable;
  } ctrl_reg_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous input followed by a registered
// one-cycle rising-edge pulse. SYNC_STAGES must be at least 2.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/trig_sequencer.sv
// Frame trigger sequencer: Avalon-MM register block plus a four-state FSM that
// issues frame starts from an internal timer or a synchronized external trigger.
module trig_sequencer
  import trig_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  ctrl_clk_i,
  input  logic                  ctrl_rst_i,
  input  logic                  slave_chipselect,
  input  logic [1:0]            slave_addr,
  input  logic                  slave_write,
  input  logic [DATA_WIDTH-1:0] slave_writedata,
  input  logic                  slave_read,
  output logic [DATA_WIDTH-1:0] slave_readdata,
  input  logic                  ext_trig_i,
  input  logic                  ctrl_busy_i,
  input  logic                  ctrl_done_i,
  output logic                  seq_start_o,
  output logic                  seq_laser_sel_o,
  output logic                  seq_active_o,
  output logic                  irq_o
);

  seq_state_e state_q, state_d;

  ctrl_reg_t       ctrl_q, ctrl_d;
  logic [31:0]     period_q, period_d;
  logic [15:0]     fcount_q, fcount_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [15:0]     issued_q, issued_d;
  logic [7:0]      overrun_q, overrun_d;
  logic            done_q, done_d;
  logic            laser_q, laser_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [31:0] wdata;
  logic        wr_en, rd_en, ctrl_wr, status_wr;
  logic        start_req, abort_req;
  logic [31:0] period_eff;
  logic        ext_rise, timer_hit, trig_evt, go;
  logic [15:0] issued_inc;
  logic        last_frame, frame_done, enter_issue;
  logic [31:0] rd_word;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (ctrl_clk_i),
    .rst_i   (ctrl_rst_i),
    .async_i (ext_trig_i),
    .rise_o  (ext_rise)
  );

  assign wdata     = slave_writedata[31:0];
  assign wr_en     = slave_chipselect & slave_write;
  assign rd_en     = slave_chipselect & slave_read;
  assign ctrl_wr   = wr_en && (slave_addr == REG_CTRL);
  assign status_wr = wr_en && (slave_addr == REG_STATUS);

  // Abort dominates start; clearing enable acts as an abort.
  assign abort_req = ctrl_wr & (wdata[CTRL_ABORT_BIT] | ~wdata[CTRL_EN_BIT]);
  assign start_req = ctrl_wr & wdata[CTRL_START_BIT] & wdata[CTRL_EN_BIT] & ~wdata[CTRL_ABORT_BIT];

  assign period_eff = (period_q == 32'd0) ? 32'd1 : period_q;
  assign timer_hit  = (cnt_q <= 32'd1);
  assign trig_evt   = ctrl_q.mode ? ext_rise : timer_hit;
  assign go         = (trig_evt | pending_q) & ~ctrl_busy_i;

  assign issued_inc  = issued_q + 16'd1;
  assign last_frame  = (fcount_q != 16'd0) && (issued_inc == fcount_q);
  assign frame_done  = (state_q == ST_WAIT_DONE) && ctrl_done_i && !abort_req;
  assign enter_issue = (state_q == ST_WAIT_TRIG) && (state_d == ST_ISSUE);

  always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
    if (ctrl_rst_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start_req) state_d = ST_WAIT_TRIG;
      ST_WAIT_TRIG: if (go)        state_d = ST_ISSUE;
      ST_ISSUE:                    state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (ctrl_done_i) state_d = last_frame ? ST_IDLE : ST_WAIT_TRIG;
      default:                     state_d = ST_IDLE;
    endcase
    if (abort_req) state_d = ST_IDLE;
  end

  always_comb begin
    seq_start_o     = (state_q == ST_ISSUE);
    seq_active_o    = (state_q != ST_IDLE);
    seq_laser_sel_o = laser_q;
    irq_o           = done_q & ctrl_q.irq_en;
    slave_readdata  = rdata_q;
  end

  // NOTE: every next-state variable gets its default first, so no path can infer a latch.
  always_comb begin
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    fcount_d  = fcount_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    issued_d  = issued_q;
    overrun_d = overrun_q;
    done_d    = done_q;
    laser_d   = laser_q;

    if (ctrl_wr) begin
      ctrl_d.enable = wdata[CTRL_EN_BIT];
      ctrl_d.mode   = wdata[CTRL_MODE_BIT];
      ctrl_d.alt    = wdata[CTRL_ALT_BIT];
      ctrl_d.irq_en = wdata[CTRL_IRQEN_BIT];
    end
    if (wr_en && slave_addr == REG_PERIOD) period_d = wdata;
    if (wr_en && slave_addr == REG_FCOUNT) fcount_d = wdata[15:0];
    if (status_wr && wdata[STAT_DONE_BIT])    done_d    = 1'b0;
    if (status_wr && wdata[STAT_OVR_CLR_BIT]) overrun_d = '0;

    if (state_q == ST_IDLE) begin
      pending_d = 1'b0;
      if (state_d == ST_WAIT_TRIG) begin
        cnt_d    = period_eff;
        issued_d = '0;
        laser_d  = 1'b0;
      end
    end else begin
      // Free-running timer; the reload on entering ISSUE also covers busy-delayed triggers.
      cnt_d = (timer_hit || enter_issue) ? period_eff : cnt_q - 32'd1;
      if (state_q == ST_WAIT_TRIG)
        pending_d = enter_issue ? 1'b0 : (pending_q | (trig_evt & ctrl_busy_i));
      else
        pending_d = 1'b0;
      if ((state_q == ST_ISSUE || state_q == ST_WAIT_DONE) && trig_evt)
        overrun_d = sat_inc8(overrun_d);
      if (frame_done) begin
        issued_d = issued_inc;
        if (ctrl_q.alt) laser_d = ~laser_q;
        if (last_frame) done_d = 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    unique case (slave_addr)
      REG_CTRL: begin
        rd_word[CTRL_EN_BIT]    = ctrl_q.enable;
        rd_word[CTRL_MODE_BIT]  = ctrl_q.mode;
        rd_word[CTRL_ALT_BIT]   = ctrl_q.alt;
        rd_word[CTRL_IRQEN_BIT] = ctrl_q.irq_en;
      end
      REG_PERIOD: rd_word = period_q;
      REG_FCOUNT: rd_word[15:0] = fcount_q;
      REG_STATUS: begin
        rd_word[15:0]                       = issued_q;
        rd_word[STAT_OVR_LSB +: 8]          = overrun_q;
        rd_word[STAT_DONE_BIT]              = done_q;
      end
      default: rd_word = '0;
    endcase
    rdata_d = rd_en ? DATA_WIDTH'(rd_word) : rdata_q;
  end

  always_ff @(posedge ctrl_clk_i or posedge ctrl_rst_i) begin
    if (ctrl_rst_i) begin
      ctrl_q    <= '0;
      period_q  <= '0;
      fcount_q  <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      issued_q  <= '0;
      overrun_q <= '0;
      done_q    <= 1'b0;
      laser_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      period_q  <= period_d;
      fcount_q  <= fcount_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      issued_q  <= issued_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      laser_q   <= laser_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_trig_sequencer.sv
// Self-checking bench for trig_sequencer: a scoreboard of expected frame-start
// cycles and laser selects, plus register and output checks.
module tb_trig_sequencer;
  import trig_seq_pkg::*;

  localparam int DW = 32;
  localparam int SS = 2;

  localparam logic [31:0] C_EN    = 32'd1 << CTRL_EN_BIT;
  localparam logic [31:0] C_MODE  = 32'd1 << CTRL_MODE_BIT;
  localparam logic [31:0] C_ALT   = 32'd1 << CTRL_ALT_BIT;
  localparam logic [31:0] C_START = 32'd1 << CTRL_START_BIT;
  localparam logic [31:0] C_ABORT = 32'd1 << CTRL_ABORT_BIT;
  localparam logic [31:0] C_IRQEN = 32'd1 << CTRL_IRQEN_BIT;
  localparam logic [31:0] S_DONE  = 32'd1 << STAT_DONE_BIT;
  localparam logic [31:0] S_OCLR  = 32'd1 << STAT_OVR_CLR_BIT;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs, wr_s, rd_s;
  logic [1:0]    addr;
  logic [DW-1:0] wdata, rdata;
  logic          ext_trig, busy, done;
  logic          start_o, laser_o, active_o, irq;

  trig_sequencer #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .ctrl_clk_i       (clk),
    .ctrl_rst_i       (rst),
    .slave_chipselect (cs),
    .slave_addr       (addr),
    .slave_write      (wr_s),
    .slave_writedata  (wdata),
    .slave_read       (rd_s),
    .slave_readdata   (rdata),
    .ext_trig_i       (ext_trig),
    .ctrl_busy_i      (busy),
    .ctrl_done_i      (done),
    .seq_start_o      (start_o),
    .seq_laser_sel_o  (laser_o),
    .seq_active_o     (active_o),
    .irq_o            (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int   at;
    logic laser;
  } exp_start_t;

  exp_start_t sb_q[$];
  int done_delay = 4;
  int done_at    = -1;

  // Downstream controller model: returns done a fixed delay after each start.
  always @(posedge clk) begin
    #1;
    done = (cyc == done_at);
  end

  always @(negedge clk) begin
    if (!rst && start_o) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_start", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_start_t e;
        e = sb_q.pop_front();
        check("start_cycle", 32'(cyc), 32'(e.at));
        check("start_laser", 32'(laser_o), 32'(e.laser));
      end
      if (done_delay > 0) done_at = cyc + done_delay;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wr_s = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr_s = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    cs = 1'b1; rd_s = 1'b1; addr = a;
    @(posedge clk);
    #1;
    cs = 1'b0; rd_s = 1'b0;
    d = rdata;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int k = 0;
    while (active_o && k < max_cyc) begin
      idle(1);
      k++;
    end
    check(tag, 32'(active_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int t, e0, fall;

    rst = 1'b1; cs = 1'b0; wr_s = 1'b0; rd_s = 1'b0; addr = '0; wdata = '0;
    ext_trig = 1'b0; busy = 1'b0; done = 1'b0;
    #1;
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_active", 32'(active_o), 32'd0);
    check("rst_laser", 32'(laser_o), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      reg_rd(2'(a), v);
      check($sformatf("rst_reg%0d", a), v, 32'd0);
    end

    // Internal timer, three frames.
    reg_wr(REG_PERIOD, 32'd10);
    reg_wr(REG_FCOUNT, 32'd3);
    t = cyc;
    sb_q.push_back('{t + 11, 1'b0});
    sb_q.push_back('{t + 21, 1'b0});
    sb_q.push_back('{t + 31, 1'b0});
    reg_wr(REG_CTRL, C_EN | C_START);
    check("int_active", 32'(active_o), 32'd1);
    wait_idle(100, "int_idle");
    check("int_sb_empty", 32'(sb_q.size()), 32'd0);
    reg_rd(REG_STATUS, v);
    check("int_status", v, S_DONE | 32'd3);
    check("int_irq_off", 32'(irq), 32'd0);

    // Alternating laser, four frames, then irq enable/clear.
    reg_wr(REG_STATUS, S_DONE);
    reg_wr(REG_PERIOD, 32'd8);
    reg_wr(REG_FCOUNT, 32'd4);
    t = cyc;
    sb_q.push_back('{t + 9,  1'b0});
    sb_q.push_back('{t + 17, 1'b1});
    sb_q.push_back('{t + 25, 1'b0});
    sb_q.push_back('{t + 33, 1'b1});
    reg_wr(REG_CTRL, C_EN | C_ALT | C_START);
    wait_idle(100, "alt_idle");
    check("alt_sb_empty", 32'(sb_q.size()), 32'd0);
    reg_rd(REG_STATUS, v);
    check("alt_status", v, S_DONE | 32'd4);
    check("alt_irq_masked", 32'(irq), 32'd0);
    reg_wr(REG_CTRL, C_EN | C_ALT | C_IRQEN);
    check("alt_irq_on", 32'(irq), 32'd1);
    reg_wr(REG_STATUS, S_DONE);
    check("alt_irq_cleared", 32'(irq), 32'd0);

    // Busy held over timer expiry: one start, the cycle after busy falls.
    reg_wr(REG_CTRL, C_EN);
    reg_wr(REG_PERIOD, 32'd10);
    reg_wr(REG_FCOUNT, 32'd1);
    reg_wr(REG_CTRL, C_EN | C_START);
    idle(4);
    busy = 1'b1;
    idle(20);
    busy = 1'b0;
    fall = cyc;
    sb_q.push_back('{fall + 1, 1'b0});
    wait_idle(100, "busy_idle");
    check("busy_sb_empty", 32'(sb_q.size()), 32'd0);
    reg_rd(REG_STATUS, v);
    check("busy_status", v, S_DONE | 32'd1);
    reg_wr(REG_STATUS, S_DONE);

    // PERIOD 0 behaves as 1; long done delay saturates the overrun count.
    done_delay = 400;
    reg_wr(REG_PERIOD, 32'd0);
    t = cyc;
    sb_q.push_back('{t + 2, 1'b0});
    reg_wr(REG_CTRL, C_EN | C_START);
    wait_idle(600, "sat_idle");
    reg_rd(REG_STATUS, v);
    check("sat_status", v, S_DONE | (32'd255 << STAT_OVR_LSB) | 32'd1);
    reg_wr(REG_STATUS, S_DONE | S_OCLR);
    reg_rd(REG_STATUS, v);
    check("sat_cleared", v, 32'd1);

    // External trigger: edges 50 apart, done 80 after start -> every other edge dropped.
    done_delay = 80;
    reg_wr(REG_PERIOD, 32'd1000);
    reg_wr(REG_FCOUNT, 32'd0);
    reg_wr(REG_CTRL, C_EN | C_MODE | C_START);
    idle(3);
    e0 = cyc;
    for (int k = 0; k < 8; k++) begin
      ext_trig = 1'b1;
      if (k % 2 == 0) sb_q.push_back('{cyc + SS + 2, 1'b0});
      idle(10);
      ext_trig = 1'b0;
      idle(40);
    end
    check("ext_span", 32'(cyc - e0), 32'd400);
    reg_wr(REG_CTRL, C_EN | C_MODE | C_ABORT);
    done_at = -1;
    check("ext_abort_idle", 32'(active_o), 32'd0);
    check("ext_sb_empty", 32'(sb_q.size()), 32'd0);
    reg_rd(REG_STATUS, v);
    check("ext_status", v, (32'd4 << STAT_OVR_LSB) | 32'd4);
    reg_wr(REG_STATUS, S_OCLR);

    // Abort in WAIT_DONE, start+abort together, and enable cleared mid-run.
    done_delay = 100;
    reg_wr(REG_PERIOD, 32'd10);
    t = cyc;
    sb_q.push_back('{t + 11, 1'b0});
    reg_wr(REG_CTRL, C_EN | C_START);
    idle(13);
    reg_wr(REG_CTRL, C_EN | C_ABORT);
    done_at = -1;
    check("abort_idle", 32'(active_o), 32'd0);
    idle(30);
    reg_rd(REG_STATUS, v);
    check("abort_done_clear", 32'(v[STAT_DONE_BIT]), 32'd0);
    reg_wr(REG_CTRL, C_EN | C_START | C_ABORT);
    check("start_abort_idle", 32'(active_o), 32'd0);
    idle(30);
    reg_wr(REG_CTRL, C_EN | C_START);
    idle(3);
    check("dis_running", 32'(active_o), 32'd1);
    reg_wr(REG_CTRL, 32'd0);
    check("dis_idle", 32'(active_o), 32'd0);
    idle(30);
    check("abort_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset asserted while in ISSUE.
    done_delay = 4;
    reg_wr(REG_PERIOD, 32'd5);
    reg_wr(REG_CTRL, C_EN | C_IRQEN | C_START);
    idle(5);
    check("pre_rst_issue", 32'(start_o), 32'd1);
    rst = 1'b1;
    #1;
    done_at = -1;
    check("rst_issue_start", 32'(start_o), 32'd0);
    check("rst_issue_active", 32'(active_o), 32'd0);
    check("rst_issue_laser", 32'(laser_o), 32'd0);
    check("rst_issue_irq", 32'(irq), 32'd0);
    check("rst_issue_rdata", rdata, 32'd0);
    idle(2);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      reg_rd(2'(a), v);
      check($sformatf("rst2_reg%0d", a), v, 32'd0);
    end
    idle(20);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
